// File: rtl/mem_pkg.sv
// Shared defaults for the byte-maskable register-file bank and a helper
// that derives the number of byte lanes from the data width.
package mem_pkg;

  localparam int MEM_DW    = 16;
  localparam int MEM_DEPTH = 6;
  localparam int MEM_AW    = 3;

  // One byte-enable bit per 8-bit lane of the data word.
  function automatic int lane_count(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/mem_row.sv
// One storage row of the bank: DW bits, synchronous clear, and a write
// strobe qualified per byte lane by the be mask.
module mem_row
  import mem_pkg::*;
#(
  parameter int DW = MEM_DW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr,
  input  logic [lane_count(DW)-1:0] be,
  input  logic [DW-1:0]             din,
  output logic [DW-1:0]             q
);

  localparam int NB = lane_count(DW);

  // Row storage: clear wins, otherwise only enabled lanes take new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (wr) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) q[8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_bank.sv
// Small register-file bank: DEPTH rows of DW bits with byte-lane writes,
// one-cycle registered reads, and a one-cycle err pulse for any access
// beyond the last row (out-of-range reads return zero).
// Optional build macro MEM_BANK_CLR_EN adds a clr input that zeroes the
// rows without touching dout; rst outranks clr, clr outranks any access.
module mem_bank
  import mem_pkg::*;
#(
  parameter int DW    = MEM_DW,
  parameter int DEPTH = MEM_DEPTH,
  parameter int AW    = MEM_AW
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef MEM_BANK_CLR_EN
  input  logic                      clr,
`endif
  input  logic                      cs,
  input  logic                      we,
  input  logic [lane_count(DW)-1:0] be,
  input  logic [AW-1:0]             addr,
  input  logic [DW-1:0]             din,
  output logic [DW-1:0]             dout,
  output logic                      rvalid,
  output logic                      err
);

  logic            clr_i;
  logic            row_rst;
  logic            in_range;
  logic [DW-1:0]   rdata;
  logic [DW-1:0]   row_q [DEPTH];
  logic [DEPTH-1:0] wr;

`ifdef MEM_BANK_CLR_EN
  assign clr_i = clr;
`else
  assign clr_i = 1'b0;
`endif

  // Both rst and clr wipe the storage; only rst also clears the outputs.
  assign row_rst  = rst | clr_i;
  assign in_range = ({1'b0, addr} < (AW+1)'(DEPTH));

  // Address decode: an out-of-range address matches no row, so it writes nothing.
  for (genvar g = 0; g < DEPTH; g++) begin : g_row
    assign wr[g] = cs && we && !clr_i && (addr == AW'(g));

    mem_row #(.DW(DW)) u_row (
      .clk (clk),
      .rst (row_rst),
      .wr  (wr[g]),
      .be  (be),
      .din (din),
      .q   (row_q[g])
    );
  end

  // Read mux: zero unless the address selects an existing row.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == AW'(i)) rdata = row_q[i];
    end
  end

  // Output registers: pulses default low each cycle; dout moves only on a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout   <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      if (cs && !clr_i) begin
        err <= !in_range;
        if (!we) begin
          dout   <= in_range ? rdata : '0;
          rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bank.sv
// Directed bench for mem_bank at DW=16, DEPTH=6, AW=3.
// Build with MEM_BANK_CLR_EN defined to also exercise the clr port.
module tb_mem_bank;

  localparam int DW    = 16;
  localparam int DEPTH = 6;
  localparam int AW    = 3;

  logic          clk;
  logic          rst;
  logic          clr;
  logic          cs;
  logic          we;
  logic [1:0]    be;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          rvalid;
  logic          err;

  int n_tests;
  int n_fail;

  logic [DW-1:0] exp_row [DEPTH];

  mem_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef MEM_BANK_CLR_EN
    .clr    (clr),
`endif
    .cs     (cs),
    .we     (we),
    .be     (be),
    .addr   (addr),
    .din    (din),
    .dout   (dout),
    .rvalid (rvalid),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the edge.
  task automatic cycle(input logic c, input logic w, input logic [1:0] b,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    cs = c; we = w; be = b; addr = a; din = d;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic wr_row(input logic [AW-1:0] a, input logic [1:0] b, input logic [DW-1:0] d);
    cycle(1'b1, 1'b1, b, a, d);
  endtask

  task automatic rd_row(input logic [AW-1:0] a);
    cycle(1'b1, 1'b0, 2'b11, a, '0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'b00, '0, '0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; clr = 1'b0; cs = 1'b0; we = 1'b0; be = '0; addr = '0; din = '0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_dout", dout, 16'h0000);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;

    // Full-word write then read back
    wr_row(3'd2, 2'b11, 16'hA5C3);
    check("wr2_rvalid", rvalid, 1'b0);
    check("wr2_err", err, 1'b0);
    rd_row(3'd2);
    check("rd2_dout", dout, 16'hA5C3);
    check("rd2_rvalid", rvalid, 1'b1);
    check("rd2_err", err, 1'b0);

    // Low-lane-only write merges with existing high byte
    wr_row(3'd4, 2'b11, 16'h1234);
    wr_row(3'd4, 2'b01, 16'hFFFF);
    rd_row(3'd4);
    check("rd4_lane_lo", dout, 16'h12FF);
    // High-lane-only write
    wr_row(3'd4, 2'b10, 16'hAB00);
    rd_row(3'd4);
    check("rd4_lane_hi", dout, 16'hABFF);
    // be=0 write: no change, no flag
    wr_row(3'd4, 2'b00, 16'h0000);
    check("be0_err", err, 1'b0);
    rd_row(3'd4);
    check("rd4_be0", dout, 16'hABFF);

    // Out-of-range write
    wr_row(3'd6, 2'b11, 16'hBEEF);
    check("oor_wr_err", err, 1'b1);
    check("oor_wr_rvalid", rvalid, 1'b0);
    check("oor_wr_dout_hold", dout, 16'hABFF);
    idle();
    check("oor_err_drop", err, 1'b0);
    exp_row[0] = 16'h0000; exp_row[1] = 16'h0000; exp_row[2] = 16'hA5C3;
    exp_row[3] = 16'h0000; exp_row[4] = 16'hABFF; exp_row[5] = 16'h0000;
    for (int i = 0; i < DEPTH; i++) begin
      rd_row(AW'(i));
      check($sformatf("oor_rows_%0d", i), dout, exp_row[i]);
    end
    // Out-of-range read
    rd_row(3'd7);
    check("oor_rd_dout", dout, 16'h0000);
    check("oor_rd_rvalid", rvalid, 1'b1);
    check("oor_rd_err", err, 1'b1);
    idle();
    check("idle_rvalid", rvalid, 1'b0);
    check("idle_err", err, 1'b0);

    // Fill every row, then stream reads back-to-back
    for (int i = 0; i < DEPTH; i++) begin
      exp_row[i] = 16'h1000 + 16'(i) * 16'h1111;
      wr_row(AW'(i), 2'b11, exp_row[i]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cs = 1'b1; we = 1'b0; be = 2'b11; addr = AW'(i); din = '0;
      @(posedge clk); #1;
      check($sformatf("stream_dout_%0d", i), dout, exp_row[i]);
      check($sformatf("stream_rvalid_%0d", i), rvalid, 1'b1);
    end
    cs = 1'b0;
    @(posedge clk); #1;
    check("stream_cs0_rvalid", rvalid, 1'b0);
    check("stream_cs0_dout", dout, 16'h6555);

    // Reset during a write: access dropped, everything cleared
    rst = 1'b1;
    wr_row(3'd1, 2'b11, 16'hFFFF);
    rst = 1'b0;
    check("rst_mid_dout", dout, 16'h0000);
    check("rst_mid_rvalid", rvalid, 1'b0);
    check("rst_mid_err", err, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      rd_row(AW'(i));
      check($sformatf("post_rst_row_%0d", i), dout, 16'h0000);
      if (i == 0) check("post_rst_first_rvalid", rvalid, 1'b1);
    end

    // Read-after-write to the same address
    wr_row(3'd3, 2'b11, 16'hC0DE);
    rd_row(3'd3);
    check("raw_dout", dout, 16'hC0DE);

`ifdef MEM_BANK_CLR_EN
    for (int i = 0; i < DEPTH; i++) wr_row(AW'(i), 2'b11, 16'h5555 + 16'(i));
    rd_row(3'd0);
    check("clr_pre_dout", dout, 16'h5555);
    clr = 1'b1;
    wr_row(3'd2, 2'b11, 16'h9999);
    clr = 1'b0;
    check("clr_dout_hold", dout, 16'h5555);
    check("clr_rvalid", rvalid, 1'b0);
    check("clr_err", err, 1'b0);
    idle();
    check("clr_dout_hold2", dout, 16'h5555);
    for (int i = 0; i < DEPTH; i++) begin
      rd_row(AW'(i));
      check($sformatf("clr_row_%0d", i), dout, 16'h0000);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bank.md
MEM_BANK -- requirements
Module: mem_bank

Interface
REQ-001 SHALL have parameter DW, default 16, data width in bits; legal values are multiples of 8, from 8 to 64.
REQ-002 SHALL have parameter DEPTH, default 6, number of rows; legal range is 2 to 256.
REQ-003 SHALL have parameter AW, default 3, address width; it SHALL satisfy 2**AW >= DEPTH.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port cs, input, 1 bit: chip select; an access happens only when cs=1.
REQ-007 SHALL have port we, input, 1 bit: 1 selects a write, 0 selects a read.
REQ-008 SHALL have port be, input, DW/8 bits: byte enables; be[i] covers din[8i+7:8i].
REQ-009 SHALL have port addr, input, AW bits: row address.
REQ-010 SHALL have port din, input, DW bits: write data.
REQ-011 SHALL have port dout, output, DW bits: registered read data.
REQ-012 SHALL have port rvalid, output, 1 bit: one-cycle pulse when dout has just been updated by a read.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse for an access to an address >= DEPTH.

Function
REQ-014 Write: a rising edge with cs=1, we=1, addr<DEPTH SHALL update row[addr] only in the byte lanes where be=1; all other lanes hold.
REQ-015 A write with be=0 SHALL leave the row unchanged and raise no flag.
REQ-016 Read: a rising edge with cs=1, we=0, addr<DEPTH SHALL load dout with row[addr] and set rvalid=1; read latency is 1 cycle.
REQ-017 Whenever no read is performed, dout SHALL hold its last value and rvalid SHALL be 0.
REQ-018 A read of address A in the cycle right after a write to A SHALL return the newly written data.
REQ-019 Out-of-range write (addr>=DEPTH) SHALL change no row and SHALL set err=1 for one cycle.
REQ-020 Out-of-range read SHALL load dout with 0, set rvalid=1 and set err=1, each for one cycle.
REQ-021 With cs=0, no row, dout, rvalid or err SHALL change, except that rvalid and err clear to 0.
REQ-022 Back-to-back accesses SHALL be accepted every cycle with no stall; there is no backpressure.

Reset
REQ-023 While rst=1 at a rising edge, every row, dout, rvalid and err SHALL become 0.
REQ-024 Reset SHALL take priority over any access in the same cycle; that access is dropped.
REQ-025 The first access SHALL be accepted on the first rising edge after rst falls.

Configuration
REQ-026 Macro MEM_BANK_CLR_EN defined: the block SHALL add input port clr (1 bit) after rst.
REQ-027 With the macro, clr=1 at a rising edge SHALL zero all rows, leave dout unchanged and drop any concurrent access.
REQ-028 With the macro, rst SHALL have priority over clr, and clr over any access.
REQ-029 Macro undefined: there SHALL be no clr port, and only rst clears the storage.

Structure
REQ-030 Package mem_pkg SHALL hold the default constants MEM_DW, MEM_DEPTH and MEM_AW, plus a function that computes the byte-lane count.
REQ-031 A sub-module mem_row SHALL implement one DW-bit row with synchronous reset, a write strobe and a be mask; mem_bank instantiates DEPTH copies.
REQ-032 The read mux and the address decode SHALL live in mem_bank, and all outputs SHALL be driven directly from registers.

Verification (DW=16, DEPTH=6, AW=3)
REQ-033 Write 0xA5C3 to addr 2 with be=11, then read addr 2 -> next cycle dout=0xA5C3, rvalid=1, err=0.
REQ-034 Row 4 holds 0x1234; write 0xFFFF with be=01, then read -> dout=0x12FF.
REQ-035 Write addr 6 with din=0xBEEF -> err=1 for one cycle, rows 0-5 unchanged; read addr 7 -> dout=0x0000, rvalid=1, err=1.
REQ-036 Write all rows, assert rst for one cycle during a write to addr 1 -> all rows read 0x0000, and dout=0, rvalid=0, err=0 right after reset.
REQ-037 Reads of addrs 0..5 on consecutive cycles with cs held high -> rvalid high 6 cycles, dout sequence matches rows; then cs=0 -> rvalid=0, dout holds row 5.
REQ-038 With MEM_BANK_CLR_EN: rows nonzero, dout=0x5555, pulse clr -> all rows read 0, dout stays 0x5555 until the next read.
